array_sum_engine: RTL and testbench
===================================

Name: array_sum_engine

Overview:
- Memory-side sequencer that sits directly upstream of the data memory in the CA3 multicycle datapath and drives its Address/WriteData/MemRead/MemWrite inputs.
- On a start pulse it reads COUNT consecutive words beginning at a base address and accumulates them. It then writes the 32-bit sum back to a destination word address and reports completion.
- Used for self-checking array-sum runs, e.g. words 0..9 initialised to 10..100 give 550.

Parameters:
- DEPTH, 32, number of words in the attached data memory; all word addresses are taken modulo DEPTH.
- CNT_W, 6, width of the count input (0..DEPTH inclusive).

Ports:
- clk  input  1  rising-edge clock, shared with the data memory
- rst  input  1  synchronous, active-low reset
- start  input  1  one-cycle request; sampled only in IDLE
- base_addr  input  32  first word address to read
- count  input  CNT_W  number of words to sum; 0 is legal
- dest_addr  input  32  word address receiving the sum
- busy  output  1  high from the cycle after start acceptance until the write completes
- done  output  1  one-cycle completion pulse
- sum  output  32  last completed result; held until the next completion
- mem_addr  output  32  to data memory Address
- mem_wdata  output  32  to data memory WriteData
- mem_read  output  1  to data memory MemRead
- mem_write  output  1  to data memory MemWrite
- mem_rdata  input  32  from data memory ReadData; valid combinationally in the same cycle as mem_addr/mem_read

Behaviour:
- Reset (rst=0 at a rising edge): state goes to IDLE. busy=0, done=0, sum=0, mem_addr=0, mem_wdata=0, mem_read=0, mem_write=0, and the internal accumulator, pointer and remaining count are all 0.
- Reset mid-operation aborts immediately. No write is issued and sum returns to 0.
- FSM states: IDLE, READ, WRITE, DONE.
- IDLE, start=1 at edge E:
  - Latch base_addr mod DEPTH into ptr, count into rem, and dest_addr mod DEPTH into dst.
  - Clear the accumulator.
  - Go to READ if count!=0, otherwise go to WRITE.
- IDLE, start=0: stay in IDLE.
- READ:
  - Outputs: mem_read=1, mem_write=0, mem_addr=ptr.
  - Each edge: acc <= acc + mem_rdata (mod 2^32, carry discarded); ptr <= (ptr+1) mod DEPTH; rem <= rem-1.
  - When rem==1 at the edge, go to WRITE.
  - Exactly count read cycles are performed.
- WRITE:
  - Outputs: mem_write=1, mem_read=0, mem_addr=dst, mem_wdata=acc.
  - All are held stable for the whole cycle.
  - Next edge: sum <= acc, go to DONE.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE. A new start is accepted only from the following IDLE cycle.
- busy=1 in READ and WRITE only.
- mem_read and mem_write are never high together. Both are 0 in IDLE and DONE, and mem_addr=0 there.
- Latency: if start is accepted at edge E, done is high in the cycle after edge E+count+1. Examples: count=10 → done after E+11; count=0 → done after E+1.
- start asserted while not in IDLE is ignored and not queued. Inputs other than start are don't-care outside the accepting edge.
- Address wrap: base=DEPTH-2, count=4 reads DEPTH-2, DEPTH-1, 0, 1.
- count>DEPTH is legal; reads wrap and re-read words.
- dest_addr may lie inside the read range. The write occurs after all reads, so it does not affect the current sum.

Test Plan:
- Memory[0..9]=10..100; start with base=0, count=10, dest=20 → 10 mem_read cycles at addresses 0..9, then one mem_write to address 20 with data 550. done pulses 12 cycles after the start edge; sum=550; Memory[20]=550.
- count=0, dest=5 → no read cycles. One write of 0 to address 5, done on the second cycle after start, sum=0.
- Memory[30]=1, [31]=2, [0]=10, [1]=20; base=30, count=4, dest=12 → read addresses 30, 31, 0, 1; sum=33.
- Memory[0]=0xFFFFFFFF, Memory[1]=2; base=0, count=2 → sum=0x00000001 (wraps mod 2^32).
- Drive rst=0 during the 5th read of the count=10 run → next cycle busy=0, sum=0, no mem_write seen. A following full run still yields 550.
- Pulse start again during READ with a different base → ignored; the result equals the original request and there is exactly one done pulse.

Source files
------------

// File: rtl/array_sum_engine.sv
`default_nettype none
// ============================================================================
// Module   : array_sum_engine
// Brief    : Reads COUNT consecutive words from the data memory, sums them and
//            writes the 32-bit result back to a destination word address.
// Revision : 1.0
// ============================================================================
module array_sum_engine #(
    parameter int DEPTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      base_addr,
    input  logic [CNT_W-1:0] count,
    input  logic [31:0]      dest_addr,
    output logic             busy,
    output logic             done,
    output logic [31:0]      sum,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic             mem_read,
    output logic             mem_write,
    input  logic [31:0]      mem_rdata
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [AW-1:0] c_last_ptr = AW'(DEPTH - 1);

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic [AW-1:0]    r_ptr;
    logic [AW-1:0]    r_dst;
    logic [CNT_W-1:0] r_rem;
    logic [31:0]      r_acc;
    logic [31:0]      r_sum;

    logic [AW-1:0]    w_base_ptr;
    logic [AW-1:0]    w_dest_ptr;
    logic [AW-1:0]    w_ptr_inc;
    logic             w_accept;

    // Addresses are folded into the memory range once, at acceptance.
    assign w_base_ptr = AW'(base_addr % 32'(DEPTH));
    assign w_dest_ptr = AW'(dest_addr % 32'(DEPTH));
    assign w_ptr_inc  = (r_ptr == c_last_ptr) ? '0 : r_ptr + AW'(1);
    assign w_accept   = (r_state == S_IDLE) && start;
    assign sum        = r_sum;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = (count != '0) ? S_READ : S_WRITE;
                end
            end
            S_READ: begin
                if (r_rem == CNT_W'(1)) begin
                    w_next_state = S_WRITE;
                end
            end
            S_WRITE: w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        case (r_state)
            S_READ: begin
                busy     = 1'b1;
                mem_read = 1'b1;
                mem_addr = 32'(r_ptr);
            end
            S_WRITE: begin
                busy      = 1'b1;
                mem_write = 1'b1;
                mem_addr  = 32'(r_dst);
                mem_wdata = r_acc;
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ptr <= '0;
            r_dst <= '0;
            r_rem <= '0;
            r_acc <= '0;
            r_sum <= '0;
        end else begin
            if (w_accept) begin
                r_ptr <= w_base_ptr;
                r_dst <= w_dest_ptr;
                r_rem <= count;
                r_acc <= '0;
            end else if (r_state == S_READ) begin
                r_acc <= r_acc + mem_rdata;
                r_ptr <= w_ptr_inc;
                r_rem <= r_rem - CNT_W'(1);
            end
            if (r_state == S_WRITE) begin
                r_sum <= r_acc;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_array_sum_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_array_sum_engine
// Brief    : Directed, table-driven bench for array_sum_engine with a
//            combinational-read memory model.
// Revision : 1.0
// ============================================================================
module tb_array_sum_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [31:0] base_addr = '0;
    logic [5:0]  count = '0;
    logic [31:0] dest_addr = '0;
    logic        busy;
    logic        done;
    logic [31:0] sum;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:31];

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          base;
        int          cnt;
        int          dst;
        logic [31:0] exp_sum;
    } vec_t;

    vec_t vecs [7];

    array_sum_engine #(.DEPTH(32), .CNT_W(6)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .count     (count),
        .dest_addr (dest_addr),
        .busy      (busy),
        .done      (done),
        .sum       (sum),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[4:0]];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Words 0..31 hold 10, 20, ..., 320.
    task automatic init_mem();
        for (int i = 0; i < 32; i++) mem[i] = 32'(10 * (i + 1));
    endtask

    task automatic run(input string name, input int base, input int cnt, input int dst,
                       input logic [31:0] exp_sum, input int glitch_k, input int abort_k);
        int  reads = 0;
        int  writes = 0;
        int  busy_n = 0;
        int  done_k = -1;
        int  extra = 0;
        int  both = 0;
        int  exp_ptr;
        int  wr_addr = -1;
        logic [31:0] wr_data = '0;
        logic [31:0] dst_before;
        bit  aborted = 0;

        dst_before = mem[dst % 32];
        exp_ptr    = base % 32;
        @(negedge clk);
        base_addr = 32'(base);
        count     = 6'(cnt);
        dest_addr = 32'(dst);
        start     = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;

        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (mem_read && mem_write) both++;
            if (mem_read) begin
                check({name, " read_addr"}, mem_addr, 32'(exp_ptr));
                exp_ptr = (exp_ptr + 1) % 32;
                reads++;
            end
            if (mem_write) begin
                writes++;
                wr_addr = int'(mem_addr);
                wr_data = mem_wdata;
                mem[mem_addr[4:0]] = mem_wdata;
            end
            if (busy) busy_n++;
            start = 1'b0;
            if (k == glitch_k) begin
                base_addr = 32'd10;
                count     = 6'd2;
                dest_addr = 32'd1;
                start     = 1'b1;
            end
            if (k == abort_k) begin
                rst = 1'b0;
                @(negedge clk);
                check({name, " abort_busy"}, 32'(busy), 32'd0);
                check({name, " abort_sum"}, sum, 32'd0);
                check({name, " abort_write"}, 32'(writes + int'(mem_write)), 32'd0);
                check({name, " abort_mem"}, mem[dst % 32], dst_before);
                rst = 1'b1;
                aborted = 1;
                break;
            end
            if (done) begin
                done_k = k;
                check({name, " done_outputs"}, {mem_addr[29:0], mem_read, mem_write}, 32'd0);
                break;
            end
        end
        if (aborted) return;

        check({name, " latency"}, 32'(done_k), 32'(cnt + 1));
        check({name, " reads"}, 32'(reads), 32'(cnt));
        check({name, " writes"}, 32'(writes), 32'd1);
        check({name, " wr_addr"}, 32'(wr_addr), 32'(dst % 32));
        check({name, " wr_data"}, wr_data, exp_sum);
        check({name, " sum"}, sum, exp_sum);
        check({name, " mem_dst"}, mem[dst % 32], exp_sum);
        check({name, " busy_cycles"}, 32'(busy_n), 32'(cnt + 1));
        check({name, " rd_wr_overlap"}, 32'(both), 32'd0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (done || busy || mem_read || mem_write) extra++;
        end
        check({name, " idle_after"}, 32'(extra), 32'd0);
        check({name, " sum_held"}, sum, exp_sum);
    endtask

    initial begin
        vecs[0] = '{base: 0,  cnt: 10, dst: 20, exp_sum: 32'd550};
        vecs[1] = '{base: 0,  cnt: 0,  dst: 5,  exp_sum: 32'd0};
        vecs[2] = '{base: 30, cnt: 4,  dst: 12, exp_sum: 32'd660};
        vecs[3] = '{base: 5,  cnt: 1,  dst: 0,  exp_sum: 32'd60};
        vecs[4] = '{base: 31, cnt: 33, dst: 3,  exp_sum: 32'd5600};
        vecs[5] = '{base: 40, cnt: 2,  dst: 36, exp_sum: 32'd190};
        vecs[6] = '{base: 2,  cnt: 3,  dst: 3,  exp_sum: 32'd120};

        init_mem();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_sum", sum, 32'd0);
        check("reset_mem_addr", mem_addr, 32'd0);
        check("reset_mem_wdata", mem_wdata, 32'd0);
        check("reset_rd_wr", {30'd0, mem_read, mem_write}, 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            init_mem();
            run($sformatf("vec%0d", i), vecs[i].base, vecs[i].cnt, vecs[i].dst,
                vecs[i].exp_sum, -1, -1);
        end

        init_mem();
        mem[30] = 32'd1; mem[31] = 32'd2; mem[0] = 32'd10; mem[1] = 32'd20;
        run("wrap", 30, 4, 12, 32'd33, -1, -1);

        init_mem();
        mem[0] = 32'hFFFF_FFFF; mem[1] = 32'd2;
        run("carry", 0, 2, 7, 32'd1, -1, -1);

        init_mem();
        run("abort", 0, 10, 20, 32'd550, -1, 4);
        init_mem();
        run("after_abort", 0, 10, 20, 32'd550, -1, -1);

        init_mem();
        run("ignored_start", 0, 10, 20, 32'd550, 3, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
